urv_decode_sb: RTL and testbench

URV_DECODE_SB -- requirements
Module: urv_decode_sb

---
 rtl/urv_decode_sb.sv | 272 +++++++++++++++++++++++++++
 tb/tb_urv_decode_sb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_decode_sb.sv
// urv_decode_sb -- instruction decode stage with a register scoreboard.
//
// Decodes the fetched instruction into registered execute-stage fields and
// tracks multi-cycle results (loads, multiplies, shifts) in a small
// scoreboard. When a source operand depends on a pending result, or no slot
// is free for a new multi-cycle result, it requests a stall from fetch and
// inserts a bubble.
//
// Parameters:
//   g_slots      scoreboard entries (1..8)
//   g_load_lat   load result latency in cycles (1..7)
//   g_mul_lat    multiply result latency (1..7)
//   g_shift_lat  shifter result latency (1..7)
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   d_stall_i          downstream stall: hold all state
//   d_kill_i           flush: next captured x_valid_o is 0
//   d_stall_req_o      hazard stall request to fetch (combinational)
//   f_ir_i/f_pc_i/f_valid_i  fetched instruction, PC, valid
//   rf_rs1_o/rf_rs2_o  register file read addresses (combinational)
//   x_*                registered execute-stage fields
//   x_class_o          0 ALU, 1 LOAD, 2 STORE, 3 SHIFT, 4 MUL, 5 DIV, 6 CSR, 7 BR/JMP
//   sb_busy_o          one bit per register with a pending write
//   stat_stall_cnt_o   saturating count of hazard-stalled edges
//                      (only when URV_DECODE_STATS_EN is defined)

module urv_decode_sb #(
  parameter int unsigned g_slots     = 4,
  parameter int unsigned g_load_lat  = 2,
  parameter int unsigned g_mul_lat   = 2,
  parameter int unsigned g_shift_lat = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        d_stall_i,
  input  logic        d_kill_i,
  output logic        d_stall_req_o,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  input  logic        f_valid_i,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic        x_valid_o,
  output logic [31:0] x_pc_o,
  output logic [4:0]  x_rd_o,
  output logic [4:0]  x_opcode_o,
  output logic [2:0]  x_fun_o,
  output logic [31:0] x_imm_o,
  output logic        x_rd_write_o,
  output logic [2:0]  x_class_o,
  output logic [31:0] sb_busy_o
`ifdef URV_DECODE_STATS_EN
  ,
  output logic [31:0] stat_stall_cnt_o
`endif
);

  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000,
    OPC_OP_IMM = 5'b00100,
    OPC_AUIPC  = 5'b00101,
    OPC_STORE  = 5'b01000,
    OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101,
    OPC_BRANCH = 5'b11000,
    OPC_JALR   = 5'b11001,
    OPC_JAL    = 5'b11011,
    OPC_SYSTEM = 5'b11100
  } opcode_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_SHIFT, CLS_MUL, CLS_DIV, CLS_CSR, CLS_BRJ
  } class_t;

  logic [4:0]  w_opc, w_rd, w_rs1, w_rs2;
  logic [2:0]  w_fun;
  logic [31:0] w_imm;
  class_t      w_class;
  logic        w_wr_op, w_rd_write, w_use_rs1, w_use_rs2;
  logic [2:0]  w_lat;
  logic        w_multi;
  logic        w_raw, w_all_valid, w_stall_req, w_cap_valid, w_do_alloc, w_taken;
  logic [31:0] w_busy;
  logic        w_alloc [g_slots];
  logic        w_unused;

  logic        r_sv   [g_slots];
  logic [4:0]  r_srd  [g_slots];
  logic [2:0]  r_scnt [g_slots];

  assign w_opc    = f_ir_i[6:2];
  assign w_rd     = f_ir_i[11:7];
  assign w_fun    = f_ir_i[14:12];
  assign w_rs1    = f_ir_i[19:15];
  assign w_rs2    = f_ir_i[24:20];
  assign w_unused = ^f_ir_i[1:0];

  assign rf_rs1_o = w_rs1;
  assign rf_rs2_o = w_rs2;

  always_comb begin
    w_imm     = '0;
    w_class   = CLS_ALU;
    w_wr_op   = 1'b0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_wr_op   = 1'b1;
        w_use_rs2 = 1'b1;
        if (f_ir_i[31:25] == 7'b0000001)
          w_class = f_ir_i[14] ? CLS_DIV : CLS_MUL;
        else if (w_fun == 3'b001 || w_fun == 3'b101)
          w_class = CLS_SHIFT;
      end
      OPC_OP_IMM: begin
        w_wr_op = 1'b1;
        w_imm   = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
        if (w_fun == 3'b001 || w_fun == 3'b101)
          w_class = CLS_SHIFT;
      end
      OPC_LOAD: begin
        w_wr_op = 1'b1;
        w_imm   = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
        w_class = CLS_LOAD;
      end
      OPC_STORE: begin
        w_imm     = {{20{f_ir_i[31]}}, f_ir_i[31:25], f_ir_i[11:7]};
        w_class   = CLS_STORE;
        w_use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm     = {{19{f_ir_i[31]}}, f_ir_i[31], f_ir_i[7], f_ir_i[30:25], f_ir_i[11:8], 1'b0};
        w_class   = CLS_BRJ;
        w_use_rs2 = 1'b1;
      end
      OPC_JALR: begin
        w_wr_op = 1'b1;
        w_imm   = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
        w_class = CLS_BRJ;
      end
      OPC_JAL: begin
        w_wr_op   = 1'b1;
        w_imm     = {{11{f_ir_i[31]}}, f_ir_i[31], f_ir_i[19:12], f_ir_i[20], f_ir_i[30:21], 1'b0};
        w_class   = CLS_BRJ;
        w_use_rs1 = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_wr_op   = 1'b1;
        w_imm     = {f_ir_i[31:12], 12'b0};
        w_use_rs1 = 1'b0;
      end
      OPC_SYSTEM: begin
        w_wr_op = (w_fun != 3'b000);
        w_class = CLS_CSR;
      end
      default: ;
    endcase
  end

  assign w_rd_write = w_wr_op && (w_rd != 5'd0);

  always_comb begin
    case (w_class)
      CLS_LOAD:  w_lat = 3'(g_load_lat);
      CLS_MUL:   w_lat = 3'(g_mul_lat);
      CLS_SHIFT: w_lat = 3'(g_shift_lat);
      default:   w_lat = 3'd1;
    endcase
  end

  assign w_multi = (w_lat > 3'd1);

  always_comb begin
    w_raw       = 1'b0;
    w_all_valid = 1'b1;
    w_busy      = '0;
    for (int unsigned i = 0; i < g_slots; i++) begin
      w_all_valid = w_all_valid & r_sv[i];
      if (r_sv[i]) begin
        w_busy[r_srd[i]] = 1'b1;
        if ((w_use_rs1 && w_rs1 != 5'd0 && w_rs1 == r_srd[i]) ||
            (w_use_rs2 && w_rs2 != 5'd0 && w_rs2 == r_srd[i]))
          w_raw = 1'b1;
      end
    end
    w_busy[0] = 1'b0;
  end

  // A slot retiring at this edge only becomes allocatable at the next one,
  // so a full scoreboard stalls any multi-cycle instruction even if an
  // entry is about to expire.
  assign w_stall_req = f_valid_i && !d_kill_i && (w_raw || (w_all_valid && w_multi));
  assign w_cap_valid = f_valid_i && !d_kill_i && !w_stall_req;
  assign w_do_alloc  = w_cap_valid && w_rd_write && w_multi;

  always_comb begin
    w_taken = 1'b0;
    for (int unsigned i = 0; i < g_slots; i++) begin
      w_alloc[i] = 1'b0;
      if (!r_sv[i] && !w_taken) begin
        w_alloc[i] = 1'b1;
        w_taken    = 1'b1;
      end
    end
  end

  assign d_stall_req_o = w_stall_req;
  assign sb_busy_o     = w_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_valid_o    <= 1'b0;
      x_pc_o       <= '0;
      x_rd_o       <= '0;
      x_opcode_o   <= '0;
      x_fun_o      <= '0;
      x_imm_o      <= '0;
      x_rd_write_o <= 1'b0;
      x_class_o    <= '0;
    end else if (!d_stall_i) begin
      x_valid_o    <= w_cap_valid;
      x_pc_o       <= f_pc_i;
      x_rd_o       <= w_rd;
      x_opcode_o   <= w_opc;
      x_fun_o      <= w_fun;
      x_imm_o      <= w_imm;
      x_rd_write_o <= w_rd_write;
      x_class_o    <= w_class;
    end else if (d_kill_i) begin
      x_valid_o <= 1'b0;
    end
  end

  // Kill does not touch the slots: pending entries simply age out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < g_slots; i++) begin
        r_sv[i]   <= 1'b0;
        r_srd[i]  <= '0;
        r_scnt[i] <= '0;
      end
    end else if (!d_stall_i) begin
      for (int unsigned i = 0; i < g_slots; i++) begin
        if (r_sv[i]) begin
          if (r_scnt[i] == 3'd1)
            r_sv[i] <= 1'b0;
          r_scnt[i] <= r_scnt[i] - 3'd1;
        end else if (w_do_alloc && w_alloc[i]) begin
          r_sv[i]   <= 1'b1;
          r_srd[i]  <= w_rd;
          r_scnt[i] <= w_lat - 3'd1;
        end
      end
    end
  end

`ifdef URV_DECODE_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_stall_cnt <= '0;
    else if (w_stall_req && !d_stall_i && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stat_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_urv_decode_sb.sv
module tb_urv_decode_sb;

  localparam logic [4:0] OP_LD = 5'h00, OP_IMM = 5'h04, OP_AUIPC = 5'h05,
                         OP_ST = 5'h08, OP_OP = 5'h0C, OP_LUI = 5'h0D,
                         OP_BR = 5'h18, OP_JALR = 5'h19, OP_JAL = 5'h1B,
                         OP_SYS = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n, d_stall, d_kill, f_valid;
  logic [31:0] f_ir, f_pc;

  // instance A: defaults (4 slots, all latencies 2)
  logic        a_req, a_xv, a_rdw;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_opc;
  logic [2:0]  a_fun, a_cls;
  logic [31:0] a_pc, a_imm, a_busy;
  // instance B: 2 slots, load latency 4, mul latency 3
  logic        b_req, b_xv, b_rdw;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_opc;
  logic [2:0]  b_fun, b_cls;
  logic [31:0] b_pc, b_imm, b_busy;
`ifdef URV_DECODE_STATS_EN
  logic [31:0] a_stat, b_stat;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  urv_decode_sb u_a (
    .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(d_stall), .d_kill_i(d_kill),
    .d_stall_req_o(a_req), .f_ir_i(f_ir), .f_pc_i(f_pc), .f_valid_i(f_valid),
    .rf_rs1_o(a_rs1), .rf_rs2_o(a_rs2), .x_valid_o(a_xv), .x_pc_o(a_pc),
    .x_rd_o(a_rd), .x_opcode_o(a_opc), .x_fun_o(a_fun), .x_imm_o(a_imm),
    .x_rd_write_o(a_rdw), .x_class_o(a_cls), .sb_busy_o(a_busy)
`ifdef URV_DECODE_STATS_EN
    , .stat_stall_cnt_o(a_stat)
`endif
  );

  urv_decode_sb #(.g_slots(2), .g_load_lat(4), .g_mul_lat(3), .g_shift_lat(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(d_stall), .d_kill_i(d_kill),
    .d_stall_req_o(b_req), .f_ir_i(f_ir), .f_pc_i(f_pc), .f_valid_i(f_valid),
    .rf_rs1_o(b_rs1), .rf_rs2_o(b_rs2), .x_valid_o(b_xv), .x_pc_o(b_pc),
    .x_rd_o(b_rd), .x_opcode_o(b_opc), .x_fun_o(b_fun), .x_imm_o(b_imm),
    .x_rd_write_o(b_rdw), .x_class_o(b_cls), .sb_busy_o(b_busy)
`ifdef URV_DECODE_STATS_EN
    , .stat_stall_cnt_o(b_stat)
`endif
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] op);
    return {f7, rs2, rs1, f3, rd, op, 2'b11};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] op);
    return {imm, rs1, f3, rd, op, 2'b11};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_ST, 2'b11};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR, 2'b11};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [4:0] op);
    return {imm, rd, op, 2'b11};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL, 2'b11};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    f_valid = 1'b0;
    d_stall = 1'b0;
    d_kill  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
    f_ir    = ir;
    f_pc    = pc;
    f_valid = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  opc;
    logic [2:0]  fun;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rdw;
    logic [2:0]  cls;
  } vec_t;

  vec_t vecs [19];

  initial begin #200000; $display("FAIL watchdog: bench exceeded time limit"); $fatal; end

  initial begin
    vecs[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP_OP),    5'h0C, 3'd0, 32'h00000000, 5'd3,  1'b1, 3'd0};
    vecs[1]  = '{enc_i(12'hFFB, 5'd1, 3'd0, 5'd4, OP_IMM),       5'h04, 3'd0, 32'hFFFFFFFB, 5'd4,  1'b1, 3'd0};
    vecs[2]  = '{enc_i(12'h003, 5'd1, 3'd1, 5'd5, OP_IMM),       5'h04, 3'd1, 32'h00000003, 5'd5,  1'b1, 3'd3};
    vecs[3]  = '{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd6, OP_OP),    5'h0C, 3'd0, 32'h00000000, 5'd6,  1'b1, 3'd4};
    vecs[4]  = '{enc_r(7'h01, 5'd2, 5'd1, 3'd4, 5'd7, OP_OP),    5'h0C, 3'd4, 32'h00000000, 5'd7,  1'b1, 3'd5};
    vecs[5]  = '{enc_i(12'h010, 5'd1, 3'd2, 5'd8, OP_LD),        5'h00, 3'd2, 32'h00000010, 5'd8,  1'b1, 3'd1};
    vecs[6]  = '{enc_s(12'hFFC, 5'd2, 5'd1, 3'd2),               5'h08, 3'd2, 32'hFFFFFFFC, 5'd28, 1'b0, 3'd2};
    vecs[7]  = '{enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0),              5'h18, 3'd0, 32'hFFFFFFF8, 5'd25, 1'b0, 3'd7};
    vecs[8]  = '{enc_u(20'h12345, 5'd9, OP_LUI),                 5'h0D, 3'd5, 32'h12345000, 5'd9,  1'b1, 3'd0};
    vecs[9]  = '{enc_u(20'hFFFFF, 5'd10, OP_AUIPC),              5'h05, 3'd7, 32'hFFFFF000, 5'd10, 1'b1, 3'd0};
    vecs[10] = '{enc_j(21'h000800, 5'd1),                        5'h1B, 3'd0, 32'h00000800, 5'd1,  1'b1, 3'd7};
    vecs[11] = '{enc_j(21'h1FFFFC, 5'd2),                        5'h1B, 3'd7, 32'hFFFFFFFC, 5'd2,  1'b1, 3'd7};
    vecs[12] = '{enc_i(12'h000, 5'd1, 3'd0, 5'd0, OP_JALR),      5'h19, 3'd0, 32'h00000000, 5'd0,  1'b0, 3'd7};
    vecs[13] = '{enc_i(12'h300, 5'd1, 3'd1, 5'd11, OP_SYS),      5'h1C, 3'd1, 32'h00000000, 5'd11, 1'b1, 3'd6};
    vecs[14] = '{32'h00000073,                                   5'h1C, 3'd0, 32'h00000000, 5'd0,  1'b0, 3'd6};
    vecs[15] = '{enc_i(12'h402, 5'd1, 3'd5, 5'd12, OP_IMM),      5'h04, 3'd5, 32'h00000402, 5'd12, 1'b1, 3'd3};
    vecs[16] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd13, OP_OP),   5'h0C, 3'd1, 32'h00000000, 5'd13, 1'b1, 3'd3};
    vecs[17] = '{32'h0000000F,                                   5'h03, 3'd0, 32'h00000000, 5'd0,  1'b0, 3'd0};
    vecs[18] = '{enc_r(7'h01, 5'd2, 5'd1, 3'd1, 5'd14, OP_OP),   5'h0C, 3'd1, 32'h00000000, 5'd14, 1'b1, 3'd4};

    // reset state, with a valid fetch presented
    rst_n = 1'b0; d_stall = 1'b0; d_kill = 1'b0; f_valid = 1'b1;
    f_ir = enc_r(7'h00, 5'd17, 5'd9, 3'd0, 5'd3, OP_OP); f_pc = 32'h0;
    #1;
    chk("reset x_valid", 32'(a_xv), 32'h0);
    chk("reset stall_req", 32'(a_req), 32'h0);
    chk("reset busy", a_busy, 32'h0);
    chk("reset x_rd_write", 32'(a_rdw), 32'h0);
    chk("rf_rs1", 32'(a_rs1), 32'd9);
    chk("rf_rs2", 32'(a_rs2), 32'd17);
    do_reset();

    // decode table
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].ir, 32'h100 + 32'(i) * 32'd4);
      chk($sformatf("vec%0d stall_req", i), 32'(a_req), 32'h0);
      edge1();
      chk($sformatf("vec%0d x_valid", i), 32'(a_xv), 32'h1);
      chk($sformatf("vec%0d x_pc", i), a_pc, 32'h100 + 32'(i) * 32'd4);
      chk($sformatf("vec%0d opcode", i), 32'(a_opc), 32'(vecs[i].opc));
      chk($sformatf("vec%0d fun", i), 32'(a_fun), 32'(vecs[i].fun));
      chk($sformatf("vec%0d imm", i), a_imm, vecs[i].imm);
      chk($sformatf("vec%0d rd", i), 32'(a_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d rd_write", i), 32'(a_rdw), 32'(vecs[i].rdw));
      chk($sformatf("vec%0d class", i), 32'(a_cls), 32'(vecs[i].cls));
      f_valid = 1'b0;
      repeat (4) edge1();
    end

    // lw x5 ; add x6,x5,x1 with load latency 2 -> one bubble
    do_reset();
    drive(enc_i(12'h0, 5'd2, 3'd2, 5'd5, OP_LD), 32'h200);
    edge1();
    chk("lat2 lw x_valid", 32'(a_xv), 32'h1);
    chk("lat2 busy x5", a_busy, 32'h00000020);
    drive(enc_r(7'h00, 5'd1, 5'd5, 3'd0, 5'd6, OP_OP), 32'h204);
    chk("lat2 raw stall_req", 32'(a_req), 32'h1);
    edge1();
    chk("lat2 bubble x_valid", 32'(a_xv), 32'h0);
    chk("lat2 busy cleared", a_busy, 32'h0);
    chk("lat2 stall released", 32'(a_req), 32'h0);
    edge1();
    chk("lat2 add x_valid", 32'(a_xv), 32'h1);
    chk("lat2 add rd", 32'(a_rd), 32'd6);
    f_valid = 1'b0;

    // lw x7 ; addi x8,x7,1 with load latency 4 -> three bubbles
    do_reset();
    drive(enc_i(12'h0, 5'd2, 3'd2, 5'd7, OP_LD), 32'h300);
    edge1();
    chk("lat4 lw x_valid", 32'(b_xv), 32'h1);
    drive(enc_i(12'h001, 5'd7, 3'd0, 5'd8, OP_IMM), 32'h304);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lat4 stall_req %0d", k), 32'(b_req), 32'h1);
      chk($sformatf("lat4 busy %0d", k), b_busy, 32'h00000080);
      edge1();
      chk($sformatf("lat4 bubble %0d", k), 32'(b_xv), 32'h0);
    end
    chk("lat4 busy cleared", b_busy, 32'h0);
    chk("lat4 stall released", 32'(b_req), 32'h0);
    edge1();
    chk("lat4 addi x_valid", 32'(b_xv), 32'h1);
    chk("lat4 addi rd", 32'(b_rd), 32'd8);
    f_valid = 1'b0;

    // two slots, mul latency 3: third mul waits for a slot
    do_reset();
    drive(enc_r(7'h01, 5'd5, 5'd4, 3'd0, 5'd1, OP_OP), 32'h400);
    edge1();
    chk("struct busy after mul1", b_busy, 32'h00000002);
    drive(enc_r(7'h01, 5'd5, 5'd4, 3'd0, 5'd2, OP_OP), 32'h404);
    chk("struct mul2 no stall", 32'(b_req), 32'h0);
    edge1();
    chk("struct busy after mul2", b_busy, 32'h00000006);
    drive(enc_r(7'h01, 5'd5, 5'd4, 3'd0, 5'd3, OP_OP), 32'h408);
    chk("struct mul3 stall_req", 32'(b_req), 32'h1);
    edge1();
    chk("struct bubble", 32'(b_xv), 32'h0);
    chk("struct busy after free", b_busy, 32'h00000004);
    chk("struct stall released", 32'(b_req), 32'h0);
    edge1();
    chk("struct mul3 x_valid", 32'(b_xv), 32'h1);
    chk("struct mul3 rd", 32'(b_rd), 32'd3);
    chk("struct busy mul3", b_busy, 32'h00000008);
    f_valid = 1'b0;

    // lw x0 ; add x1,x0,x0 -> no hazard, nothing busy
    do_reset();
    drive(enc_i(12'h0, 5'd1, 3'd2, 5'd0, OP_LD), 32'h500);
    edge1();
    chk("x0 busy", a_busy, 32'h0);
    chk("x0 rd_write", 32'(a_rdw), 32'h0);
    drive(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, OP_OP), 32'h504);
    chk("x0 no stall", 32'(a_req), 32'h0);
    edge1();
    chk("x0 add x_valid", 32'(a_xv), 32'h1);
    f_valid = 1'b0;

    // kill during RAW stall: slot keeps aging on schedule
    do_reset();
    drive(enc_i(12'h0, 5'd2, 3'd2, 5'd7, OP_LD), 32'h600);
    edge1();
    drive(enc_i(12'h001, 5'd7, 3'd0, 5'd8, OP_IMM), 32'h604);
    chk("kill raw stall_req", 32'(b_req), 32'h1);
    d_kill = 1'b1;
    #1;
    chk("kill stall_req low", 32'(b_req), 32'h0);
    edge1();
    chk("kill x_valid", 32'(b_xv), 32'h0);
    chk("kill busy kept", b_busy, 32'h00000080);
    d_kill = 1'b0; f_valid = 1'b0;
    edge1();
    chk("kill busy aging", b_busy, 32'h00000080);
    edge1();
    chk("kill busy expired", b_busy, 32'h0);

    // downstream stall holds state; kill under stall still drops x_valid
    do_reset();
    drive(enc_i(12'h0, 5'd2, 3'd2, 5'd5, OP_LD), 32'h700);
    edge1();
    d_stall = 1'b1;
    drive(enc_r(7'h00, 5'd1, 5'd5, 3'd0, 5'd6, OP_OP), 32'h704);
    chk("hold stall_req comb", 32'(a_req), 32'h1);
    edge1();
    chk("hold x_valid", 32'(a_xv), 32'h1);
    chk("hold x_rd", 32'(a_rd), 32'd5);
    chk("hold busy", a_busy, 32'h00000020);
    d_kill = 1'b1;
    #1;
    edge1();
    chk("stall kill x_valid", 32'(a_xv), 32'h0);
    chk("stall kill busy", a_busy, 32'h00000020);
    chk("stall kill pc held", a_pc, 32'h00000700);
    d_stall = 1'b0; d_kill = 1'b0; f_valid = 1'b0;
    edge1();
    chk("unstall busy expired", a_busy, 32'h0);

    // reset pulsed mid-stall with two slots valid
    do_reset();
    drive(enc_i(12'h0, 5'd2, 3'd2, 5'd7, OP_LD), 32'h800);
    edge1();
    drive(enc_i(12'h0, 5'd2, 3'd2, 5'd9, OP_LD), 32'h804);
    chk("rst lw2 no stall", 32'(b_req), 32'h0);
    edge1();
    chk("rst two slots", b_busy, 32'h00000280);
    drive(enc_i(12'h001, 5'd7, 3'd0, 5'd8, OP_IMM), 32'h808);
    chk("rst pre stall_req", 32'(b_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst x_valid", 32'(b_xv), 32'h0);
    chk("rst x_pc", b_pc, 32'h0);
    chk("rst x_imm", b_imm, 32'h0);
    chk("rst x_rd", 32'(b_rd), 32'h0);
    chk("rst x_opcode", 32'(b_opc), 32'h0);
    chk("rst x_fun", 32'(b_fun), 32'h0);
    chk("rst x_class", 32'(b_cls), 32'h0);
    chk("rst x_rd_write", 32'(b_rdw), 32'h0);
    chk("rst stall_req", 32'(b_req), 32'h0);
    chk("rst busy", b_busy, 32'h0);
`ifdef URV_DECODE_STATS_EN
    chk("rst stat", b_stat, 32'h0);
`endif
    #1 rst_n = 1'b1;
    #1;
    chk("post rst no stall", 32'(b_req), 32'h0);
    edge1();
    chk("post rst addi x_valid", 32'(b_xv), 32'h1);
    chk("post rst addi rd", 32'(b_rd), 32'd8);
    f_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
